// File: rtl/pgm_snd_pkg.sv
// Shared encodings and width helpers for the PGM 68k <-> Z80 sound mailbox.
package pgm_snd_pkg;

    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    // Value returned by reads that have nothing to deliver.
    function automatic logic [63:0] all_ones_f(input int w);
        return {64{1'b1}} >> (64 - w);
    endfunction

    function automatic int ch_width_f(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int ptr_width_f(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/pgm_sync_fifo.sv
// Single-clock command FIFO; pointers carry an extra wrap bit so full and empty
// are distinguished without a separate count.
module pgm_sync_fifo
    import pgm_snd_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = ptr_width_f(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Pointer advance; the parent only asserts push/pop when they are legal.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since empty gates every read.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/pgm_sound_mailbox.sv
// Multi-channel 68k->Z80 command FIFOs with Z80->68k reply registers, status
// registers on both sides and a maskable level interrupt to the Z80.
module pgm_sound_mailbox
    import pgm_snd_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CH_W       = ch_width_f(NUM_CH)
) (
    input  logic              fixed_20m_clk,
    input  logic              reset,
    input  logic              m_wr,
    input  logic              m_rd,
    input  logic              m_reg,
    input  logic [CH_W-1:0]   m_ch,
    input  logic [DATA_W-1:0] m_din,
    output logic [DATA_W-1:0] m_dout,
    input  logic              z_wr,
    input  logic              z_rd,
    input  logic              z_reg,
    input  logic [CH_W-1:0]   z_ch,
    input  logic [DATA_W-1:0] z_din,
    output logic [DATA_W-1:0] z_dout,
    output logic              z_int_n
);

    localparam logic [DATA_W-1:0] ONES     = DATA_W'(all_ones_f(DATA_W));
    localparam logic [CH_W:0]     NUM_CH_C = (CH_W+1)'(NUM_CH);

    logic [DATA_W-1:0] reply_q [NUM_CH];
    logic [DATA_W-1:0] reply_d [NUM_CH];
    logic [DATA_W-1:0] head_s  [NUM_CH];
    logic [NUM_CH-1:0] rvalid_q, rvalid_d, ovf_q, ovf_d, mask_q, mask_d;
    logic [NUM_CH-1:0] full_s, empty_s, push_s, pop_s, ovf_set_s;
    logic [DATA_W-1:0] m_dout_q, m_dout_d, z_dout_q, z_dout_d;
    logic [DATA_W-1:0] m_stat_s, z_stat_s;
    logic              int_n_q, int_n_d;
    logic              m_rd_s, z_rd_s, m_ch_ok_s, z_ch_ok_s;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pgm_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk_i   (fixed_20m_clk),
            .rst_i   (reset),
            .push_i  (push_s[c]),
            .pop_i   (pop_s[c]),
            .din_i   (m_din),
            .head_o  (head_s[c]),
            .full_o  (full_s[c]),
            .empty_o (empty_s[c])
        );
    end

    // Strobe qualification: a write beats a read, out-of-range channels do nothing.
    always_comb begin
        m_rd_s    = m_rd & ~m_wr;
        z_rd_s    = z_rd & ~z_wr;
        m_ch_ok_s = ({1'b0, m_ch} < NUM_CH_C);
        z_ch_ok_s = ({1'b0, z_ch} < NUM_CH_C);
        pop_s     = {NUM_CH{1'b0}};
        push_s    = {NUM_CH{1'b0}};
        ovf_set_s = {NUM_CH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            pop_s[c] = z_rd_s && (z_reg == REG_DATA) && z_ch_ok_s &&
                       (z_ch == CH_W'(c)) && !empty_s[c];
            // A pop in the same cycle frees the slot the push lands in.
            if (m_wr && (m_reg == REG_DATA) && m_ch_ok_s && (m_ch == CH_W'(c))) begin
                push_s[c]    = !full_s[c] || pop_s[c];
                ovf_set_s[c] = full_s[c] && !pop_s[c];
            end else begin
                push_s[c]    = 1'b0;
                ovf_set_s[c] = 1'b0;
            end
        end
        m_stat_s = {DATA_W{1'b0}};
        m_stat_s[NUM_CH-1:0]        = rvalid_q;
        m_stat_s[2*NUM_CH-1:NUM_CH] = full_s;
        z_stat_s = {DATA_W{1'b0}};
        z_stat_s[NUM_CH-1:0]        = ~empty_s;
        z_stat_s[2*NUM_CH-1:NUM_CH] = ovf_q;
    end

    // Register next-state: 68k side first so a same-cycle reply write wins rvalid.
    always_comb begin
        reply_d  = reply_q;
        rvalid_d = rvalid_q;
        mask_d   = mask_q;
        ovf_d    = ovf_q;
        m_dout_d = m_dout_q;
        z_dout_d = z_dout_q;
        if (m_rd_s) begin
            if (m_reg == REG_STATUS) begin
                m_dout_d = m_stat_s;
            end else if (m_ch_ok_s) begin
                m_dout_d         = reply_q[m_ch];
                rvalid_d[m_ch]   = 1'b0;
            end else begin
                m_dout_d = ONES;
            end
        end else if (m_wr && (m_reg == REG_STATUS)) begin
            mask_d = m_din[NUM_CH-1:0];
        end else begin
            mask_d = mask_q;
        end
        if (z_wr && (z_reg == REG_DATA) && z_ch_ok_s) begin
            reply_d[z_ch]  = z_din;
            rvalid_d[z_ch] = 1'b1;
        end else begin
            rvalid_d = rvalid_d;
        end
        if (z_rd_s) begin
            if (z_reg == REG_STATUS) begin
                z_dout_d = z_stat_s;
                ovf_d    = {NUM_CH{1'b0}};
            end else if (z_ch_ok_s && !empty_s[z_ch]) begin
                z_dout_d = head_s[z_ch];
            end else begin
                z_dout_d = ONES;
            end
        end else begin
            z_dout_d = z_dout_q;
        end
        ovf_d   = ovf_d | ovf_set_s;
        int_n_d = ~|(~empty_s & mask_q);
    end

    // State and output registers.
    always_ff @(posedge fixed_20m_clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                reply_q[c] <= {DATA_W{1'b0}};
            end
            rvalid_q <= {NUM_CH{1'b0}};
            ovf_q    <= {NUM_CH{1'b0}};
            mask_q   <= {NUM_CH{1'b1}};
            m_dout_q <= {DATA_W{1'b0}};
            z_dout_q <= {DATA_W{1'b0}};
            int_n_q  <= 1'b1;
        end else begin
            reply_q  <= reply_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            mask_q   <= mask_d;
            m_dout_q <= m_dout_d;
            z_dout_q <= z_dout_d;
            int_n_q  <= int_n_d;
        end
    end

    assign m_dout  = m_dout_q;
    assign z_dout  = z_dout_q;
    assign z_int_n = int_n_q;

endmodule

// File: tb/tb_pgm_sound_mailbox.sv
// Directed self-checking bench for pgm_sound_mailbox with default parameters.
module tb_pgm_sound_mailbox;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       m_wr = 1'b0, m_rd = 1'b0, m_reg = 1'b0;
    logic [1:0] m_ch = 2'd0;
    logic [7:0] m_din = 8'h00;
    logic [7:0] m_dout;
    logic       z_wr = 1'b0, z_rd = 1'b0, z_reg = 1'b0;
    logic [1:0] z_ch = 2'd0;
    logic [7:0] z_din = 8'h00;
    logic [7:0] z_dout;
    logic       z_int_n;

    int passed = 0;
    int total  = 0;

    localparam logic D = 1'b0;
    localparam logic S = 1'b1;

    pgm_sound_mailbox dut (
        .fixed_20m_clk (clk),
        .reset         (reset),
        .m_wr          (m_wr),
        .m_rd          (m_rd),
        .m_reg         (m_reg),
        .m_ch          (m_ch),
        .m_din         (m_din),
        .m_dout        (m_dout),
        .z_wr          (z_wr),
        .z_rd          (z_rd),
        .z_reg         (z_reg),
        .z_ch          (z_ch),
        .z_din         (z_din),
        .z_dout        (z_dout),
        .z_int_n       (z_int_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic m_set(input logic wr, input logic rd, input logic rg,
                         input logic [1:0] ch, input logic [7:0] d);
        m_wr = wr; m_rd = rd; m_reg = rg; m_ch = ch; m_din = d;
    endtask

    task automatic z_set(input logic wr, input logic rd, input logic rg,
                         input logic [1:0] ch, input logic [7:0] d);
        z_wr = wr; z_rd = rd; z_reg = rg; z_ch = ch; z_din = d;
    endtask

    // Strobes set at a falling edge are seen by one rising edge, then cleared.
    task automatic step();
        @(negedge clk);
        m_wr = 1'b0; m_rd = 1'b0; z_wr = 1'b0; z_rd = 1'b0;
    endtask

    task automatic m_write(input logic rg, input logic [1:0] ch, input logic [7:0] d);
        m_set(1'b1, 1'b0, rg, ch, d); step();
    endtask

    task automatic z_write(input logic rg, input logic [1:0] ch, input logic [7:0] d);
        z_set(1'b1, 1'b0, rg, ch, d); step();
    endtask

    task automatic m_read(input string tag, input logic rg, input logic [1:0] ch,
                          input logic [7:0] exp);
        m_set(1'b0, 1'b1, rg, ch, 8'h00); step(); chk(tag, m_dout, exp);
    endtask

    task automatic z_read(input string tag, input logic rg, input logic [1:0] ch,
                          input logic [7:0] exp);
        z_set(1'b0, 1'b1, rg, ch, 8'h00); step(); chk(tag, z_dout, exp);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_m_dout", m_dout, 8'h00);
        chk("rst_z_dout", z_dout, 8'h00);
        chk("rst_int", {7'd0, z_int_n}, 8'h01);

        // Basic command path and interrupt latency on ch1.
        m_write(D, 2'd1, 8'h11);
        chk("int_1cyc", {7'd0, z_int_n}, 8'h01);
        step();
        chk("int_2cyc", {7'd0, z_int_n}, 8'h00);
        m_write(D, 2'd1, 8'h22);
        z_read("z_stat_ch1", S, 2'd0, 8'h02);
        z_read("z_pop_11", D, 2'd1, 8'h11);
        z_read("z_pop_22", D, 2'd1, 8'h22);
        z_read("z_pop_empty", D, 2'd1, 8'hFF);
        chk("int_clear", {7'd0, z_int_n}, 8'h01);

        // Overflow on ch0.
        for (int i = 0; i < 5; i++) m_write(D, 2'd0, 8'hA1 + 8'(i));
        m_read("m_stat_full", S, 2'd0, 8'h08);
        z_read("z_stat_ovf", S, 2'd0, 8'h09);
        z_read("z_stat_ovf_clr", S, 2'd0, 8'h01);
        for (int i = 0; i < 4; i++) z_read("z_pop_ovf", D, 2'd0, 8'hA1 + 8'(i));
        z_read("z_pop_ovf_end", D, 2'd0, 8'hFF);

        // Reply path on ch2.
        z_write(D, 2'd2, 8'h5A);
        m_read("m_stat_rv", S, 2'd0, 8'h04);
        m_read("m_reply", D, 2'd2, 8'h5A);
        m_read("m_stat_rv_clr", S, 2'd0, 8'h00);
        m_read("m_reply_rpt", D, 2'd2, 8'h5A);

        // Interrupt mask.
        m_write(S, 2'd0, 8'h00);
        m_write(D, 2'd0, 8'h33);
        step(); step();
        chk("int_masked", {7'd0, z_int_n}, 8'h01);
        m_write(S, 2'd0, 8'h01);
        chk("int_unmask_1", {7'd0, z_int_n}, 8'h01);
        step();
        chk("int_unmask_2", {7'd0, z_int_n}, 8'h00);
        z_read("z_pop_33", D, 2'd0, 8'h33);

        // Push and pop together on a full FIFO.
        for (int i = 0; i < 4; i++) m_write(D, 2'd0, 8'h41 + 8'(i));
        m_set(1'b1, 1'b0, D, 2'd0, 8'h77);
        z_set(1'b0, 1'b1, D, 2'd0, 8'h00);
        step();
        chk("full_pushpop", z_dout, 8'h41);
        z_read("full_no_ovf", S, 2'd0, 8'h01);
        m_read("full_still", S, 2'd0, 8'h08);
        z_read("full_pop42", D, 2'd0, 8'h42);
        z_read("full_pop43", D, 2'd0, 8'h43);
        z_read("full_pop44", D, 2'd0, 8'h44);
        z_read("full_pop77", D, 2'd0, 8'h77);

        // Push and pop together on an empty FIFO.
        m_set(1'b1, 1'b0, D, 2'd1, 8'h55);
        z_set(1'b0, 1'b1, D, 2'd1, 8'h00);
        step();
        chk("empty_pushpop", z_dout, 8'hFF);
        z_read("empty_pp_stat", S, 2'd0, 8'h02);
        z_read("empty_pp_pop", D, 2'd1, 8'h55);

        // Reply write racing a 68k read on the same channel.
        z_write(D, 2'd1, 8'h10);
        m_set(1'b0, 1'b1, D, 2'd1, 8'h00);
        z_set(1'b1, 1'b0, D, 2'd1, 8'h20);
        step();
        chk("race_old_reply", m_dout, 8'h10);
        m_read("race_rv_set", S, 2'd0, 8'h02);
        m_read("race_new_reply", D, 2'd1, 8'h20);

        // Out-of-range channel.
        m_write(D, 2'd3, 8'hC3);
        z_write(D, 2'd3, 8'hC3);
        m_read("oor_m_read", D, 2'd3, 8'hFF);
        z_read("oor_z_read", D, 2'd3, 8'hFF);
        z_read("oor_z_stat", S, 2'd0, 8'h00);
        m_read("oor_m_stat", S, 2'd0, 8'h00);

        // Reset with live state.
        m_write(D, 2'd0, 8'h01);
        m_write(D, 2'd1, 8'h02);
        z_write(D, 2'd0, 8'h99);
        step();
        chk("pre_rst_int", {7'd0, z_int_n}, 8'h00);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("post_rst_int", {7'd0, z_int_n}, 8'h01);
        m_read("post_rst_m_stat", S, 2'd0, 8'h00);
        z_read("post_rst_z_stat", S, 2'd0, 8'h00);
        m_read("post_rst_m_data", D, 2'd0, 8'h00);
        z_read("post_rst_z_data", D, 2'd0, 8'hFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
